// File: rtl/jb_pkg.sv
// Joybus shared definitions: bit timing derived from the clock rate, TX state
// encoding and the standard host command words.
package jb_pkg;

  function automatic int t_bit(input int clk_per_us);
    return 4 * clk_per_us;
  endfunction

  function automatic int t_short(input int clk_per_us);
    return clk_per_us;
  endfunction

  function automatic int t_long(input int clk_per_us);
    return 3 * clk_per_us;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    STOP_LOW
  } tx_state_e;

  localparam logic [7:0]  N64_POLL = 8'h01;
  localparam logic [23:0] GC_POLL  = 24'h400300;
  localparam logic [7:0]  JB_INFO  = 8'h00;

endpackage

// File: rtl/joybus_tx.sv
// Host-side Joybus transmitter: sends tx_len command bits MSB first as
// pulse-width encoded symbols, then a short host stop bit, via a pad enable.
module joybus_tx
  import jb_pkg::*;
#(
  parameter int CLK_PER_US = 50,
  parameter int MAX_BITS   = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_start,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic [4:0]          tx_len,
  output logic                jb_tx_oe,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int TB = t_bit(CLK_PER_US);
  localparam int TS = t_short(CLK_PER_US);
  localparam int TL = t_long(CLK_PER_US);
  localparam int PW = $clog2(TB);

  localparam logic [PW-1:0] LAST_SHORT = PW'(TS - 1);
  localparam logic [PW-1:0] LAST_LONG  = PW'(TL - 1);
  localparam logic [PW-1:0] LAST_BIT   = PW'(TB - 1);
  localparam logic [4:0]    LEN_MAX    = 5'(MAX_BITS);

  tx_state_e           state_q;
  logic                oe_q;
  logic                busy_q;
  logic                done_q;
  logic [PW-1:0]       phase_q;
  logic [4:0]          bits_q;
  logic [MAX_BITS-1:0] shift_q;

  logic [4:0]          len_sat;
  logic [MAX_BITS-1:0] data_aligned;
  logic [PW-1:0]       low_last;

  always_comb begin
    len_sat      = (tx_len > LEN_MAX) ? LEN_MAX : tx_len;
    data_aligned = tx_data << (MAX_BITS - int'(len_sat));
    // A '1' symbol holds the line low briefly, a '0' holds it low for long.
    low_last     = shift_q[MAX_BITS-1] ? LAST_SHORT : LAST_LONG;
  end

  // NOTE: every state flop uses <= so all branches see pre-edge values;
  // reset is asynchronous so the line is released the instant rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= '0;
      bits_q  <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          // busy_q is still set on the tx_done cycle, so a start there is dropped.
          if (tx_start && !busy_q) begin
            shift_q <= data_aligned;
            bits_q  <= len_sat;
            phase_q <= '0;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= (len_sat == 5'd0) ? STOP_LOW : LOW;
          end
        end
        LOW: begin
          phase_q <= phase_q + PW'(1);
          if (phase_q == low_last) begin
            oe_q    <= 1'b0;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (phase_q == LAST_BIT) begin
            phase_q <= '0;
            shift_q <= shift_q << 1;
            bits_q  <= bits_q - 5'd1;
            oe_q    <= 1'b1;
            state_q <= (bits_q == 5'd1) ? STOP_LOW : LOW;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        STOP_LOW: begin
          if (phase_q == LAST_SHORT) begin
            phase_q <= '0;
            oe_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign jb_tx_oe = oe_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_joybus_tx.sv
// Scoreboard bench for joybus_tx: expected pulse widths and frame lengths are
// queued at stimulus time and consumed by a line monitor sampling on negedge.
module tb_joybus_tx;
  import jb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [23:0] tx_data = '0;
  logic [4:0]  tx_len = '0;
  logic        jb_tx_oe, tx_busy, tx_done;

  joybus_tx #(.CLK_PER_US(50), .MAX_BITS(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_len   (tx_len),
    .jb_tx_oe (jb_tx_oe),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  typedef enum int { K_LOW, K_HIGH, K_FRAME } kind_e;
  typedef struct { kind_e kind; int val; } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;
  logic [31:0] last_decoded = '0;
  int   last_busy_drops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [23:0] d, input logic [4:0] l);
    int n;
    exp_t e;
    n = (l > 5'd24) ? 24 : int'(l);
    for (int i = n - 1; i >= 0; i--) begin
      e.kind = K_LOW;  e.val = d[i] ? 50 : 150;  exp_q.push_back(e);
      e.kind = K_HIGH; e.val = d[i] ? 150 : 50;  exp_q.push_back(e);
    end
    e.kind = K_LOW;   e.val = 50;           exp_q.push_back(e);
    e.kind = K_FRAME; e.val = 200 * n + 50; exp_q.push_back(e);
  endtask

  task automatic sb_pop(input kind_e k, input int obs, input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(obs), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_kind"}, 32'(e.kind), 32'(k));
      check(tag, 32'(obs), 32'(e.val));
    end
  endtask

  // Line monitor: measures low/high run lengths and the frame length.
  initial begin : monitor
    bit          in_frame = 0;
    logic        prev_oe = 0;
    int          run = 0;
    int          idx = 0;
    int          nbits = 0;
    int          busy_drops = 0;
    logic [31:0] dec = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0;
        prev_oe  = 0;
      end else begin
        if (in_frame) begin
          idx++;
          if (jb_tx_oe !== prev_oe) begin
            if (prev_oe) begin
              sb_pop(K_LOW, run, "low_width");
              dec = {dec[30:0], (run < 100) ? 1'b1 : 1'b0};
              nbits++;
            end else begin
              sb_pop(K_HIGH, run, "high_width");
            end
            run = 1;
          end else begin
            run++;
          end
        end else if (jb_tx_oe) begin
          in_frame = 1; idx = 0; run = 1; dec = '0; nbits = 0; busy_drops = 0;
        end
        if (in_frame) begin
          if (tx_busy !== 1'b1) busy_drops++;
          if (tx_done) begin
            sb_pop(K_FRAME, idx, "frame_len");
            last_decoded    = dec >> 1;
            last_busy_drops = busy_drops;
            done_count++;
            in_frame = 0;
          end
        end
        prev_oe = jb_tx_oe;
      end
    end
  end

  task automatic start_frame(input logic [23:0] d, input logic [4:0] l, input string tag);
    push_frame(d, l);
    @(negedge clk);
    tx_data = d; tx_len = l; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 24'($urandom);
    tx_len   = 5'($urandom);
    check({tag, "_oe_latency"}, 32'(jb_tx_oe), 32'd1);
    check({tag, "_busy_latency"}, 32'(tx_busy), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && n < budget);
    check({tag, "_done_seen"}, 32'(tx_done), 32'd1);
  endtask

  initial begin : stim
    int snap;
    repeat (3) @(negedge clk);
    check("reset_oe", 32'(jb_tx_oe), 0);
    check("reset_busy", 32'(tx_busy), 0);
    check("reset_done", 32'(tx_done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_frame(24'(N64_POLL), 5'd8, "n64");
    wait_done(3000, "n64");
    @(negedge clk);
    check("n64_busy_after", 32'(tx_busy), 0);
    check("n64_decode", last_decoded, 32'h01);
    check("n64_sb_empty", 32'(exp_q.size()), 0);

    start_frame(GC_POLL, 5'd24, "gc");
    wait_done(6000, "gc");
    @(negedge clk);
    check("gc_decode", last_decoded, 32'h400300);
    check("gc_busy_held", 32'(last_busy_drops), 0);

    start_frame(24'h0, 5'd0, "len0");
    wait_done(200, "len0");
    @(negedge clk);
    check("len0_sb_empty", 32'(exp_q.size()), 0);

    start_frame(24'hFFFFFF, 5'd31, "sat");
    wait_done(6000, "sat");
    @(negedge clk);
    check("sat_decode", last_decoded, 32'hFFFFFF);

    start_frame(GC_POLL, 5'd24, "mid");
    repeat (700) @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done(6000, "mid");
    push_frame(24'(N64_POLL), 5'd8);
    tx_data = 24'(N64_POLL); tx_len = 5'd8; tx_start = 1'b1;
    @(negedge clk);
    check("done_cycle_start_ignored", 32'(jb_tx_oe), 0);
    @(negedge clk);
    tx_start = 1'b0;
    check("b2b_oe", 32'(jb_tx_oe), 1);
    check("b2b_busy", 32'(tx_busy), 1);
    check("mid_decode", last_decoded, 32'h400300);
    wait_done(3000, "b2b");
    @(negedge clk);
    check("b2b_decode", last_decoded, 32'h01);

    start_frame(GC_POLL, 5'd24, "rst");
    repeat (1000) @(posedge clk);
    #2;
    snap = done_count;
    rst_n = 1'b0;
    #1;
    check("rst_async_oe", 32'(jb_tx_oe), 0);
    check("rst_async_busy", 32'(tx_busy), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("rst_no_done", 32'(done_count), 32'(snap));
    check("rst_idle_oe", 32'(jb_tx_oe), 0);
    start_frame(24'(N64_POLL), 5'd8, "post_rst");
    wait_done(3000, "post_rst");
    @(negedge clk);
    check("post_rst_decode", last_decoded, 32'h01);
    check("final_sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
